// File: rtl/adder_operand_sequencer.sv
// Board-side controller for the operand registers of an adder. It debounces a push button,
// issues one-cycle X/Y load strobes, and captures the registered sum after a fixed settle time.
module adder_operand_sequencer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_n,
    input  logic [WIDTH-1:0] data_in,
    output logic             load_x,
    output logic             load_y,
    output logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             carry_in,
    output logic [WIDTH:0]   result_out,
    output logic             result_valid,
    output logic [1:0]       state_out
);

    localparam int SET_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_X    = 2'b00,
        S_Y    = 2'b01,
        S_WAIT = 2'b10,
        S_SHOW = 2'b11
    } state_t;

    logic             sync_q1, sync_q2;
    logic             deb, deb_d;
    logic [CNT_W-1:0] deb_cnt;
    logic             press;

    state_t           state, state_nx;
    logic [SET_W-1:0] settle_cnt, settle_nx;
    logic             load_x_nx, load_y_nx, valid_nx;
    logic [WIDTH-1:0] operand_nx;
    logic [WIDTH:0]   result_nx;

    // The synchronizer and debounced level reset to the idle (released) value,
    // so leaving reset can never look like a press.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            deb     <= 1'b1;
            deb_d   <= 1'b1;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            sync_q1 <= key_n;
            sync_q2 <= sync_q1;
            if (sync_q2 != deb) begin
                if (deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb     <= sync_q2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
            deb_d <= deb;
            press <= deb_d & ~deb;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_X;
            settle_cnt   <= '0;
            load_x       <= 1'b0;
            load_y       <= 1'b0;
            operand      <= '0;
            result_out   <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nx;
            settle_cnt   <= settle_nx;
            load_x       <= load_x_nx;
            load_y       <= load_y_nx;
            operand      <= operand_nx;
            result_out   <= result_nx;
            result_valid <= valid_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        settle_nx  = settle_cnt;
        load_x_nx  = 1'b0;
        load_y_nx  = 1'b0;
        operand_nx = operand;
        result_nx  = result_out;
        valid_nx   = result_valid;
        case (state)
            S_X: begin
                if (press) begin
                    load_x_nx  = 1'b1;
                    operand_nx = data_in;
                    state_nx   = S_Y;
                end
            end
            S_Y: begin
                if (press) begin
                    load_y_nx  = 1'b1;
                    operand_nx = data_in;
                    settle_nx  = '0;
                    state_nx   = S_WAIT;
                end
            end
            S_WAIT: begin
                // One edge for the y register to load, then SETTLE_CYCLES for the adder path.
                if (settle_cnt == SET_W'(SETTLE_CYCLES)) begin
                    result_nx = {carry_in, sum_in};
                    valid_nx  = 1'b1;
                    state_nx  = S_SHOW;
                end else begin
                    settle_nx = settle_cnt + 1'b1;
                end
            end
            S_SHOW: begin
                if (press) begin
                    valid_nx = 1'b0;
                    state_nx = S_X;
                end
            end
        endcase
    end

    assign state_out = state;

endmodule
